// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for pipeline and load/store logic.
//   XLEN_DEFAULT  default datapath width
//   F3_*          funct3 encodings of the load instructions
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/mem_wb_stage_reg_if.sv
// MEM -> WB bus of the MEM/WB stage register.
//   mem_*  : instruction fields and raw memory word from the MEM stage
//   wb_*   : register file write port and retire count from the WB stage
// Modports: master = MEM-side producer, slave = the stage register.
interface mem_wb_stage_reg_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              mem_valid;
    logic              mem_wb_load;
    logic              mem_wb_reg_file;
    logic [2:0]        mem_funct3;
    logic [1:0]        mem_addr_lo;
    logic [XLEN-1:0]   mem_read_data;
    logic [XLEN-1:0]   mem_calculated_result;
    logic [REG_AW-1:0] mem_wb_rd;

    logic              wb_valid;
    logic              wb_write_en;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_write_data;
    logic [CNT_W-1:0]  wb_retired;

    modport master (
        output mem_valid, mem_wb_load, mem_wb_reg_file, mem_funct3, mem_addr_lo,
               mem_read_data, mem_calculated_result, mem_wb_rd,
        input  wb_valid, wb_write_en, wb_rd, wb_write_data, wb_retired
    );

    modport slave (
        input  mem_valid, mem_wb_load, mem_wb_reg_file, mem_funct3, mem_addr_lo,
               mem_read_data, mem_calculated_result, mem_wb_rd,
        output wb_valid, wb_write_en, wb_rd, wb_write_data, wb_retired
    );
endinterface

// File: rtl/load_align.sv
// Load data aligner: selects byte/half lane by address offset and extends.
//   funct3   in  load type (LB/LH/LW/LBU/LHU; anything else behaves as LW)
//   addr_lo  in  byte offset within the word
//   raw      in  raw memory word
//   aligned  out extended load value
// Misaligned halves/words use the word-aligned lanes (offset truncated).
module load_align import riscv_pkg::*; #(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] raw,
    output logic [XLEN-1:0] aligned
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = raw[7:0];
            2'd1:    byte_sel = raw[15:8];
            2'd2:    byte_sel = raw[23:16];
            default: byte_sel = raw[31:24];
        endcase
        half_sel = addr_lo[1] ? raw[31:16] : raw[15:0];

        case (funct3)
            F3_LB:   aligned = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  aligned = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   aligned = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  aligned = {{(XLEN-16){1'b0}}, half_sel};
            default: aligned = raw;
        endcase
    end
endmodule

// File: rtl/mem_wb_stage_reg.sv
// MEM/WB pipeline register with stall/flush, load alignment, writeback mux
// and a saturating retired-instruction counter.
//   clk          in  rising-edge clock
//   rst          in  asynchronous active-low reset
//   pipeline_en  in  1 = advance, 0 = hold all stage state
//   flush        in  load a bubble on the next advance
//   cnt_clr      in  synchronous clear of the retire counter (beats increment)
//   bus          slave side of mem_wb_stage_reg_if (mem_* in, wb_* out)
module mem_wb_stage_reg import riscv_pkg::*; #(
    parameter int XLEN        = XLEN_DEFAULT,
    parameter int REG_AW      = 5,
    parameter int MEM_LATENCY = 1,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pipeline_en,
    input  logic               flush,
    input  logic               cnt_clr,
    mem_wb_stage_reg_if.slave  bus
);
    logic              wb_valid_q;
    logic              wb_load_q;
    logic              wb_reg_file_q;
    logic [REG_AW-1:0] wb_rd_q;
    logic [2:0]        funct3_q;
    logic [1:0]        addr_lo_q;
    logic [XLEN-1:0]   result_q;
    logic [CNT_W-1:0]  retired_q;
    logic [XLEN-1:0]   raw_word;
    logic [XLEN-1:0]   aligned_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid_q    <= 1'b0;
            wb_load_q     <= 1'b0;
            wb_reg_file_q <= 1'b0;
            wb_rd_q       <= '0;
            funct3_q      <= '0;
            addr_lo_q     <= '0;
            result_q      <= '0;
        end else if (pipeline_en) begin
            if (flush) begin
                wb_valid_q    <= 1'b0;
                wb_load_q     <= 1'b0;
                wb_reg_file_q <= 1'b0;
                wb_rd_q       <= '0;
                funct3_q      <= '0;
                addr_lo_q     <= '0;
                result_q      <= '0;
            end else begin
                wb_valid_q    <= bus.mem_valid;
                wb_load_q     <= bus.mem_wb_load;
                wb_reg_file_q <= bus.mem_wb_reg_file;
                wb_rd_q       <= bus.mem_wb_rd;
                funct3_q      <= bus.mem_funct3;
                addr_lo_q     <= bus.mem_addr_lo;
                result_q      <= bus.mem_calculated_result;
            end
        end
    end

    generate
        if (MEM_LATENCY == 0) begin : g_reg_data
            logic [XLEN-1:0] data_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    data_q <= '0;
                else if (pipeline_en)
                    data_q <= flush ? '0 : bus.mem_read_data;
            end

            assign raw_word = data_q;
        end else begin : g_hold_data
            // Synchronous RAM output is only valid in the first WB cycle;
            // snapshot it on the first stalled edge so a held load keeps its data.
            logic            hold_q;
            logic [XLEN-1:0] hold_data;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    hold_q    <= 1'b0;
                    hold_data <= '0;
                end else if (pipeline_en) begin
                    hold_q    <= 1'b0;
                end else if (!hold_q) begin
                    hold_q    <= 1'b1;
                    hold_data <= bus.mem_read_data;
                end
            end

            assign raw_word = hold_q ? hold_data : bus.mem_read_data;
        end
    endgenerate

    load_align #(.XLEN(XLEN)) u_load_align (
        .funct3  (funct3_q),
        .addr_lo (addr_lo_q),
        .raw     (raw_word),
        .aligned (aligned_data)
    );

    // Counting on the advancing edge makes a stalled instruction count once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            retired_q <= '0;
        else if (cnt_clr)
            retired_q <= '0;
        else if (pipeline_en && wb_valid_q && (retired_q != '1))
            retired_q <= retired_q + 1'b1;
    end

    assign bus.wb_valid      = wb_valid_q;
    assign bus.wb_rd         = wb_rd_q;
    assign bus.wb_write_en   = wb_valid_q & wb_reg_file_q & (wb_rd_q != '0);
    assign bus.wb_write_data = wb_load_q ? aligned_data : result_q;
    assign bus.wb_retired    = retired_q;
endmodule

// File: doc/mem_wb_stage_reg.md
Name: mem_wb_stage_reg

Overview:
- Parametrised MEM/WB pipeline register, successor of the fixed 32-bit MEM/WB stage.
- Adds:
  - stall and flush handling with a valid bit;
  - selectable memory latency (registered or same-cycle read data);
  - stall-safe load-data holding;
  - byte/half/word load alignment with sign extension;
  - final writeback mux;
  - saturating retired-instruction counter for the benchmarking framework.
- Sits between the MEM stage/data memory and the register file write port.

Parameters:
- XLEN, 32, datapath width (32 only for RV32IM; kept generic for alignment logic).
- REG_AW, 5, register index width.
- MEM_LATENCY, 1, 1 = mem_read_data arrives in the WB cycle (synchronous RAM); 0 = mem_read_data is valid in MEM and is registered.
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pipeline_en  in  1  1 = advance; 0 = hold all stage state.
- flush  in  1  insert bubble on next advance.
- mem_valid  in  1  MEM-stage instruction valid.
- mem_wb_load  in  1  instruction is a load.
- mem_wb_reg_file  in  1  instruction writes rd.
- mem_funct3  in  3  load type (LB/LH/LW/LBU/LHU).
- mem_addr_lo  in  2  load byte offset (address[1:0]).
- mem_read_data  in  XLEN  raw word from data memory.
- mem_calculated_result  in  XLEN  ALU/MUL result.
- mem_wb_rd  in  REG_AW  destination register.
- cnt_clr  in  1  synchronous clear of retire counter.
- wb_valid  out  1  WB slot holds a real instruction.
- wb_write_en  out  1  register file write enable.
- wb_rd  out  REG_AW  register file write index.
- wb_write_data  out  XLEN  register file write data.
- wb_retired  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (rst=0, async):
  - wb_valid, wb_load, wb_reg_file, wb_rd, funct3, addr_lo, result, data register, hold flag and counter all cleared to 0.
  - Consequently wb_write_en=0 and wb_write_data=0.
- Update on posedge clk when pipeline_en=1:
  - flush=1 loads a bubble: valid=0, reg_file=0, load=0. Other fields don't-care; they are zeroed.
  - Otherwise all mem_* fields are captured; valid=mem_valid.
- pipeline_en=0: every stage register holds. flush is ignored while pipeline_en=0; the MEM/hazard unit keeps flush asserted until the advance cycle.
- Latency: one cycle MEM→WB for all control/result fields.
- Read data path:
  - MEM_LATENCY=0: mem_read_data is registered with the other fields.
  - MEM_LATENCY=1: data is used combinationally in the WB cycle.
- Stall hold (MEM_LATENCY=1 only):
  - On the first clock edge with pipeline_en=0 and the hold flag clear, capture mem_read_data into hold_data and set the hold flag.
  - While the flag is set, the aligner uses hold_data.
  - The flag clears on the next edge with pipeline_en=1.
- Load alignment: byte/half is selected by addr_lo. Per funct3:
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word.
  - Misaligned LH/LW (addr_lo odd, or addr_lo≠0 for LW) uses the word-aligned lanes as if addr_lo were truncated; no trap is generated here.
  - Undefined funct3 behaves as LW.
- Combinational outputs:
  - wb_write_data = wb_load ? aligned_data : wb_calculated_result.
  - wb_write_en = wb_valid & wb_reg_file & (wb_rd≠0).
- Retire counter:
  - On a posedge with cnt_clr=1: counter←0. cnt_clr has priority over increment.
  - Else, on a posedge with pipeline_en=1 and wb_valid=1: counter+1, saturating at 2^CNT_W−1. No wrap.
  - A stalled valid instruction is counted exactly once, on the edge that releases it.
- Reset mid-stall clears the hold flag and counter immediately. The first post-reset cycle is a bubble.

Decomposition:
- Shared package riscv_pkg:
  - funct3 load encodings: F3_LB=000, F3_LH=001, F3_LW=010, F3_LBU=100, F3_LHU=101.
  - XLEN default.
- One combinational sub-module, load_align: inputs funct3, addr_lo, raw word; output aligned data. It is reused by the future LSU.

Test Plan:
- Reset/pass-through: rst low then high. Drive mem_valid=1, reg_file=1, rd=5, result=0x1234_5678 → next cycle wb_write_en=1, wb_rd=5, wb_write_data=0x1234_5678, wb_retired increments to 1 on the following edge.
- Load alignment: raw=0x80FF_7F01, LB at addr_lo=3 → 0xFFFF_FF80; LBU at addr_lo=1 → 0x0000_007F; LH at addr_lo=2 → 0xFFFF_80FF; LW → 0x80FF_7F01.
- Stall hold (MEM_LATENCY=1): load in WB with raw=0xDEAD_BEEF; pipeline_en=0 for 3 cycles while mem_read_data changes to 0x0 → wb_write_data stays 0xDEAD_BEEF; retire count +1 only once, on the release edge.
- Flush: flush=1 with pipeline_en=1 and a valid instruction (rd=7) → next cycle wb_valid=0, wb_write_en=0, counter unchanged. Same stimulus with pipeline_en=0 → WB contents unchanged.
- x0 write and counter: rd=0, reg_file=1 → wb_write_en=0 but the instruction still retires. With CNT_W=4, preload 14 and retire 3 → counter saturates at 15. Assert cnt_clr together with a retiring instruction → counter=0.
- Async reset mid-operation: drop rst between edges during a stall → all outputs 0 immediately, hold flag cleared, counter=0.
